// File: rtl/noc_pkg.sv
// Shared types and helpers for the XY mesh router: flit layout, port encoding, route decode.
package noc_pkg;

  localparam int unsigned NOC_CW = 2;
  localparam int unsigned NOC_PW = 10;
  localparam int unsigned NOC_FLIT_W = 4 * NOC_CW + NOC_PW;
  localparam int unsigned NPORT = 5;

  // Field order fixes the wire layout: dst_x in the MSBs, payload in the LSBs.
  typedef struct packed {
    logic [NOC_CW-1:0] dst_x;
    logic [NOC_CW-1:0] dst_y;
    logic [NOC_CW-1:0] hop_x;
    logic [NOC_CW-1:0] hop_y;
    logic [NOC_PW-1:0] payload;
  } flit_t;

  typedef enum logic [2:0] {
    P_L = 3'd0,
    P_W = 3'd1,
    P_E = 3'd2,
    P_N = 3'd3,
    P_S = 3'd4
  } port_e;

  // Dimension-ordered routing: resolve X first, then Y; destination only.
  function automatic port_e xy_route(input flit_t f, input logic [NOC_CW-1:0] x,
                                     input logic [NOC_CW-1:0] y);
    port_e p;
    if (f.dst_x > x) begin
      p = P_E;
    end else if (f.dst_x < x) begin
      p = P_W;
    end else if (f.dst_y > y) begin
      p = P_N;
    end else if (f.dst_y < y) begin
      p = P_S;
    end else begin
      p = P_L;
    end
    return p;
  endfunction

  // Round-robin successor in L,W,E,N,S order.
  function automatic port_e next_port(input port_e p);
    port_e n;
    if (p == P_S) begin
      n = P_L;
    end else begin
      n = port_e'(p + 3'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input flit FIFO: registered occupancy count, power-of-2 depth, wrapping pointers.
module noc_in_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  logic  pop_i,
  input  flit_t wdata_i,
  output flit_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  flit_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and count next-state; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  // Control state, cleared by reset so buffered flits are discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/noc_router_xy.sv
// 5-port XY mesh router: buffered inputs, per-output round-robin arbitration,
// registered outputs with hop-coordinate rewrite on mesh-facing ports.
module noc_router_xy
  import noc_pkg::*;
#(
  parameter int unsigned CW    = NOC_CW,
  parameter int unsigned PW    = NOC_PW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CW-1:0]                 x_in,
  input  logic [CW-1:0]                 y_in,
  input  logic [NPORT-1:0]              in_valid,
  output logic [NPORT-1:0]              in_ready,
  input  logic [NPORT*(4*CW+PW)-1:0]    in_flit,
  output logic [NPORT-1:0]              out_valid,
  input  logic [NPORT-1:0]              out_ready,
  output logic [NPORT*(4*CW+PW)-1:0]    out_flit
);

  localparam int unsigned FLIT_W = 4 * CW + PW;

  flit_t            in_flit_s [NPORT];
  flit_t            head      [NPORT];
  port_e            route     [NPORT];
  logic [NPORT-1:0] full, empty, push, pop;
  logic [NPORT-1:0] req       [NPORT];  // req[o][i]: input i's head wants output o
  logic [NPORT-1:0] gnt       [NPORT];  // gnt[o][i]: output o takes input i's head
  logic             rdy_en_q, rdy_en_d;

  // Keeps in_ready low while reset is held and for the first edge after release.
  assign rdy_en_d = 1'b1;

  // Ready-enable flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
    end
  end

  for (genvar i = 0; i < NPORT; i++) begin : g_in
    assign in_flit_s[i] = flit_t'(in_flit[i*FLIT_W +: FLIT_W]);
    assign in_ready[i]  = rdy_en_q & ~full[i];
    assign push[i]      = in_valid[i] & in_ready[i];

    noc_in_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .wdata_i (in_flit_s[i]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );

    assign route[i] = xy_route(head[i], x_in, y_in);
  end

  // Request matrix: each non-empty head requests exactly one output.
  always_comb begin
    for (int unsigned o = 0; o < NPORT; o++) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        req[o][i] = ~empty[i] & (route[i] == port_e'(o));
      end
    end
  end

  // An input pops when whichever output it targets grants it.
  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      pop = pop | gnt[o];
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    localparam bit IsLocal = (o == 0);

    port_e            ptr_q, ptr_d;
    port_e            sel;
    logic             can_load, gnt_vld;
    logic             valid_q, valid_d;
    flit_t            flit_q, flit_d;
    logic [NPORT-1:0] gnt_vec;
    logic [3:0]       cand;

    // The output register may take a new flit if it is empty or draining this cycle.
    assign can_load = ~valid_q | out_ready[o];

    // Round-robin scan of requesters starting at the pointer.
    always_comb begin
      gnt_vld = 1'b0;
      sel     = ptr_q;
      cand    = '0;
      for (int unsigned k = 0; k < NPORT; k++) begin
        cand = {1'b0, ptr_q} + 4'(k);
        if (cand >= 4'(NPORT)) begin
          cand = cand - 4'(NPORT);
        end
        if (can_load && !gnt_vld && req[o][cand[2:0]]) begin
          gnt_vld = 1'b1;
          sel     = port_e'(cand[2:0]);
        end
      end
    end

    // One-hot grant vector toward the input FIFOs.
    always_comb begin
      gnt_vec = '0;
      if (gnt_vld) begin
        gnt_vec[sel] = 1'b1;
      end
    end

    assign gnt[o] = gnt_vec;

    // Output register next-state: load on grant, hold while stalled, clear when drained.
    always_comb begin
      valid_d = valid_q;
      flit_d  = flit_q;
      ptr_d   = ptr_q;
      if (gnt_vld) begin
        valid_d = 1'b1;
        flit_d  = head[sel];
        if (!IsLocal) begin
          flit_d.hop_x = x_in;
          flit_d.hop_y = y_in;
        end
        ptr_d = next_port(sel);
      end else if (out_ready[o]) begin
        valid_d = 1'b0;
      end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        flit_q  <= '0;
        ptr_q   <= P_L;
      end else begin
        valid_q <= valid_d;
        flit_q  <= flit_d;
        ptr_q   <= ptr_d;
      end
    end

    assign out_valid[o]                   = valid_q;
    assign out_flit[o*FLIT_W +: FLIT_W]   = flit_q;
  end

endmodule

// File: tb/tb_noc_router_xy.sv
// Scoreboard bench for noc_router_xy at node (1,1): drivers queue expected flits per
// output port, a negedge monitor pops and compares on every out_valid & out_ready.
module tb_noc_router_xy;

  localparam int FW = 18;
  localparam int NP = 5;

  typedef struct packed {
    logic [2:0]    port;
    logic [FW-1:0] flit;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [1:0]        x_in, y_in;
  logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready;
  logic [NP*FW-1:0]  in_flit, out_flit;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   cyc;
  bit   t3_on;
  int   e_cnt, t3_first, t3_last;

  noc_router_xy dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flit   (in_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [FW-1:0] mk(input int dx, input int dy, input int hx, input int hy,
                                       input int pay);
    return {2'(dx), 2'(dy), 2'(hx), 2'(hy), 10'(pay)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready are high now.
  always @(negedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          logic [FW-1:0] got;
          int            idx;
          got = out_flit[o*FW +: FW];
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].port == 3'(o)) idx = j;
          end
          checks = checks + 1;
          if (idx < 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_out port=%0d got=%h want=none", o, got);
          end else begin
            if (got !== exp_q[idx].flit) begin
              failures = failures + 1;
              $display("FAIL out_flit port=%0d got=%h want=%h", o, got, exp_q[idx].flit);
            end
            exp_q.delete(idx);
          end
          if (o == 2 && t3_on) begin
            e_cnt = e_cnt + 1;
            if (e_cnt == 1) t3_first = cyc;
            t3_last = cyc;
          end
        end
      end
    end
  end

  // Drive n flits back-to-back on port p (payload incrementing), optionally queueing expectations.
  task automatic stream(input int p, input int n, input logic [FW-1:0] f0, input int eo,
                        input logic [FW-1:0] e0, input bit add_exp);
    for (int i = 0; i < n; i++) begin
      int   guard;
      exp_t e;
      @(posedge clk); #1;
      in_valid[p] = 1'b1;
      in_flit[p*FW +: FW] = f0 + FW'(i);
      guard = 0;
      while (!in_ready[p] && guard < 50) begin
        @(posedge clk); #1;
        guard = guard + 1;
      end
      if (!in_ready[p]) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL stream_ready_timeout port=%0d got=0 want=1", p);
      end else if (add_exp) begin
        e.port = 3'(eo);
        e.flit = e0 + FW'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n = n + 1;
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_drain got=%0d want=0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    t3_on     = 1'b0;
    e_cnt     = 0;
    t3_first  = 0;
    t3_last   = 0;
    x_in      = 2'd1;
    y_in      = 2'd1;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '1;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_flit_e", 32'(out_flit[2*FW +: FW]), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // 1: W in, dst (3,1) -> E out with hop rewritten to (1,1); out_valid two edges after accept
    stream(1, 1, mk(3, 1, 0, 1, 'h155), 2, mk(3, 1, 1, 1, 'h155), 1'b1);
    @(negedge clk) chk("t1_lat_early", 32'(out_valid[2]), 32'h0);
    @(negedge clk) chk("t1_lat_due", 32'(out_valid[2]), 32'h1);
    wait_drain("t1");

    // 2: local delivery is bit-identical; S, W, E (U-turn) and N routes
    stream(3, 1, mk(1, 1, 2, 3, 'h2AA), 0, mk(1, 1, 2, 3, 'h2AA), 1'b1);
    stream(0, 1, mk(1, 0, 0, 0, 'h0F0), 4, mk(1, 0, 1, 1, 'h0F0), 1'b1);
    stream(4, 1, mk(0, 2, 1, 0, 'h333), 1, mk(0, 2, 1, 1, 'h333), 1'b1);
    stream(2, 1, mk(3, 2, 0, 0, 'h011), 2, mk(3, 2, 1, 1, 'h011), 1'b1);
    stream(1, 1, mk(1, 3, 0, 0, 'h01F), 3, mk(1, 3, 1, 1, 'h01F), 1'b1);
    wait_drain("t2");

    // 3: L and W both stream to E; E pointer sits at N, so L wins first, then strict alternation
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.port = 3'd2;
      e.flit = mk(2, 0, 1, 1, 'h100 + i);
      exp_q.push_back(e);
      e.flit = mk(3, 3, 1, 1, 'h200 + i);
      exp_q.push_back(e);
    end
    t3_on = 1'b1;
    fork
      stream(0, 6, mk(2, 0, 0, 0, 'h100), 2, '0, 1'b0);
      stream(1, 6, mk(3, 3, 0, 0, 'h200), 2, '0, 1'b0);
    join
    wait_drain("t3");
    t3_on = 1'b0;
    chk("t3_e_count", 32'(e_cnt), 32'd12);
    chk("t3_e_span", 32'(t3_last - t3_first), 32'd11);

    // 4: backpressure on E; W fills output reg plus the 4-deep FIFO, then stalls
    begin
      int   acc;
      exp_t e;
      acc = 0;
      @(posedge clk); #1;
      out_ready[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        in_valid[1] = 1'b1;
        in_flit[1*FW +: FW] = mk(3, 0, 0, 0, 'h300 + acc);
        if (!in_ready[1]) break;
        e.port = 3'd2;
        e.flit = mk(3, 0, 1, 1, 'h300 + acc);
        exp_q.push_back(e);
        acc = acc + 1;
      end
      chk("t4_accepted", 32'(acc), 32'd5);
      chk("t4_in_ready_low", 32'(in_ready[1]), 32'h0);
      in_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_hold_valid", 32'(out_valid[2]), 32'h1);
      chk("t4_hold_flit", 32'(out_flit[2*FW +: FW]), 32'(mk(3, 0, 1, 1, 'h300)));
      out_ready[2] = 1'b1;
      wait_drain("t4");
      chk("t4_in_ready_back", 32'(in_ready[1]), 32'h1);
    end

    // 5: hold W FIFO at count 2 with push+pop every cycle across pointer wrap
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    stream(1, 3, mk(3, 1, 0, 0, 'h040), 2, mk(3, 1, 1, 1, 'h040), 1'b1);
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      @(posedge clk); #1;
      if (i == 0) out_ready[2] = 1'b1;
      in_valid[1] = 1'b1;
      in_flit[1*FW +: FW] = mk(3, 1, 0, 0, 'h043 + i);
      chk("t5_ready", 32'(in_ready[1]), 32'h1);
      e.port = 3'd2;
      e.flit = mk(3, 1, 1, 1, 'h043 + i);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    wait_drain("t5");

    // 6: reset mid-traffic discards buffered flits; fresh flit sees normal latency
    out_ready[2] = 1'b0;
    stream(1, 4, mk(3, 1, 0, 0, 'h3A0), 2, '0, 1'b0);
    in_valid[1] = 1'b1;
    in_flit[1*FW +: FW] = mk(3, 1, 0, 0, 'h3AF);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'h0);
    in_valid  = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen = seen | (|out_valid);
      end
      chk("t6_nothing_emitted", 32'(seen), 32'h0);
      chk("t6_in_ready_after", 32'(in_ready), 32'h1F);
    end
    stream(1, 1, mk(3, 1, 0, 0, 'h07E), 2, mk(3, 1, 1, 1, 'h07E), 1'b1);
    @(negedge clk) chk("t6_lat_early", 32'(out_valid[2]), 32'h0);
    @(negedge clk) chk("t6_lat_due", 32'(out_valid[2]), 32'h1);
    wait_drain("t6");

    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
